// File: rtl/xgmii_tx_framer.sv
// XGMII transmit framer: wraps a valid/ready byte stream in START/preamble/SFD ... TERM and
// enforces a minimum inter-packet gap. Define TX_FRAMER_ERR_EN to add the s_err injection input.
package cmn_params;
  localparam int         BLK_W     = 64;
  localparam logic [7:0] SYM_IDLE  = 8'h07;
  localparam logic [7:0] SYM_START = 8'hFB;
  localparam logic [7:0] SYM_TERM  = 8'hFD;
  localparam logic [7:0] SYM_ERR   = 8'hFE;
  localparam logic [7:0] SYM_PREAM = 8'h55;
  localparam logic [7:0] SYM_SFD   = 8'hD5;
endpackage

module xgmii_tx_framer
  import cmn_params::*;
#(
  parameter int W_DATA  = 32,
  parameter int MIN_IPG = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W_DATA-1:0]   s_data,
  input  logic [W_DATA/8-1:0] s_keep,
  input  logic                s_valid,
  input  logic                s_last,
`ifdef TX_FRAMER_ERR_EN
  input  logic                s_err,
`endif
  output logic                s_ready,
  output logic [W_DATA-1:0]   xgmii_d,
  output logic [W_DATA/8-1:0] xgmii_c,
  output logic                blk_first,
  output logic                underrun
);
  localparam int NB    = W_DATA / 8;
  localparam int BEATS = BLK_W / W_DATA;
  localparam int PH_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IPG_W = $clog2(MIN_IPG + NB + 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(BEATS - 1);
  localparam logic [IPG_W-1:0] IPG_SAT = IPG_W'(MIN_IPG);
  localparam logic [BLK_W-1:0] PRE64   = {SYM_SFD, {6{SYM_PREAM}}, SYM_START};

  typedef enum logic [2:0] {ST_IDLE, ST_PREAM, ST_DATA, ST_TERM, ST_IPG} state_t;

  state_t             state, state_nxt;
  logic [PH_W-1:0]    ph, ph_nxt;
  logic [IPG_W-1:0]   ipg_cnt, ipg_nxt;
  logic [W_DATA-1:0]  d_p0;
  logic [NB-1:0]      c_p0;
  logic               urun_p0;
  logic               start_ok;
  logic               beat_err;
  logic               full_last;
  int                 keep_k;

  // Number of contiguous valid lanes counted up from lane 0.
  function automatic int lead_ones(input logic [NB-1:0] keep);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 0; i < NB; i++) begin
      run = run & keep[i];
      if (run) n = n + 1;
    end
    return n;
  endfunction

  function automatic logic [IPG_W-1:0] sat_ipg(input logic [IPG_W-1:0] cur);
    logic [IPG_W:0] sum;
    sum = {1'b0, cur} + (IPG_W+1)'(NB);
    return (sum >= {1'b0, IPG_SAT}) ? IPG_SAT : sum[IPG_W-1:0];
  endfunction

`ifdef TX_FRAMER_ERR_EN
  assign beat_err = s_err;
`else
  assign beat_err = 1'b0;
`endif

  // ph is the block phase of the beat now on the outputs; ph_nxt is the beat being built.
  assign ph_nxt   = (BEATS == 1) ? '0 : ph + PH_W'(1);
  // Leaving IDLE now puts PREAM's first beat (two beats ahead) on block phase 0.
  assign start_ok = ((ph + PH_W'(2)) == '0);
  assign s_ready  = (state == ST_DATA);

  always_comb begin
    state_nxt = state;
    ipg_nxt   = ipg_cnt;
    d_p0      = {NB{SYM_IDLE}};
    c_p0      = '1;
    urun_p0   = 1'b0;
    keep_k    = lead_ones(s_keep);
    full_last = (keep_k == 0) || (keep_k == NB);
    case (state)
      ST_IDLE: begin
        if (s_valid && (ipg_cnt >= IPG_SAT) && start_ok) state_nxt = ST_PREAM;
      end
      ST_PREAM: begin
        d_p0    = W_DATA'(PRE64 >> (W_DATA * int'(ph_nxt)));
        c_p0    = '0;
        c_p0[0] = (ph_nxt == '0);
        if (ph_nxt == PH_LAST) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (!s_valid) begin
          d_p0    = {NB{SYM_ERR}};
          urun_p0 = 1'b1;
        end else begin
          for (int i = 0; i < NB; i++) begin
            if (!s_last || full_last || (i < keep_k)) begin
              d_p0[8*i +: 8] = beat_err ? SYM_ERR : s_data[8*i +: 8];
              c_p0[i]        = beat_err;
            end else if (i == keep_k) begin
              d_p0[8*i +: 8] = SYM_TERM;
            end
          end
          if (s_last) begin
            if (full_last) begin
              state_nxt = ST_TERM;
            end else begin
              state_nxt = ST_IPG;
              ipg_nxt   = IPG_W'(NB - 1 - keep_k);
            end
          end
        end
      end
      ST_TERM: begin
        d_p0      = {{(NB-1){SYM_IDLE}}, SYM_TERM};
        ipg_nxt   = IPG_W'(NB - 1);
        state_nxt = ST_IPG;
      end
      ST_IPG: begin
        ipg_nxt = sat_ipg(ipg_cnt);
        if (sat_ipg(ipg_cnt) >= IPG_SAT) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output stage: beat built this cycle appears on the XGMII pins next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ph        <= '0;
      ipg_cnt   <= IPG_SAT;
      xgmii_d   <= {NB{SYM_IDLE}};
      xgmii_c   <= '1;
      blk_first <= 1'b1;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ph        <= ph_nxt;
      ipg_cnt   <= ipg_nxt;
      xgmii_d   <= d_p0;
      xgmii_c   <= c_p0;
      blk_first <= (ph_nxt == '0);
      underrun  <= urun_p0;
    end
  end
endmodule
